// File: rtl/lnk_walker.sv
// -----------------------------------------------------------------------------
// lnk_walker
// Walks a singly linked list held in a 12-bit addressed, 16-bit wide memory
// and looks for the first node whose data word equals a search key.
//
// Node layout: word N = data, word N+1 = next pointer in bits [11:0]
// (bits [15:12] ignored), pointer 12'h000 = end of list.
//
// Optional feature macro: LNK_WALKER_HOP_LIMIT_EN
//   defined   : search aborts with o_hop_err after MAX_HOPS unmatched nodes
//   undefined : no hop counter, o_hop_err is always 0, MAX_HOPS unused
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous active-high reset
//   i_start        one-cycle search request, ignored while busy
//   i_head_addr    address of the first node, sampled on an accepted start
//   i_key          search value, sampled on an accepted start
//   o_mem_rd       memory read request
//   o_mem_addr     read address, stable while o_mem_rd=1
//   i_mem_ack      read complete, i_mem_rdata valid in the same cycle
//   i_mem_rdata    read data
//   o_busy         search in progress
//   o_done         one-cycle pulse at the end of a search
//   o_found        last search matched
//   o_result_addr  address of the matching node, else 12'h000
//   o_hop_err      last search aborted on the hop limit
//
// state   | meaning
// IDLE    | waiting for start
// RD_DATA | reading the data word of the current node
// RD_NEXT | reading the next pointer of the current node
// FIN     | one-cycle done pulse, back to IDLE
// -----------------------------------------------------------------------------
module lnk_walker #(
    parameter logic [11:0] MAX_HOPS = 12'd4095
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [11:0] i_head_addr,
    input  logic [15:0] i_key,
    output logic        o_mem_rd,
    output logic [11:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_found,
    output logic [11:0] o_result_addr,
    output logic        o_hop_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        RD_NEXT = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_key;
    logic [11:0] r_cur_addr;
    logic        r_mem_rd;
    logic [11:0] r_mem_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_found;
    logic [11:0] r_result_addr;
    logic        r_hop_err;

    logic [11:0] w_next_addr;
    logic [11:0] w_next_ptr;
    logic        w_match;
    logic        w_hop_last;

    // pointer word sits right after the data word; 12-bit add wraps FFF -> 000
    assign w_next_addr = r_cur_addr + 12'd1;
    assign w_next_ptr  = i_mem_rdata[11:0];
    assign w_match     = (i_mem_rdata == r_key);

`ifdef LNK_WALKER_HOP_LIMIT_EN
    logic [11:0] r_hop_cnt;

    // counter holds the number of data acks already taken, so the ack that
    // arrives while it equals MAX_HOPS-1 is the last permitted node
    assign w_hop_last = (r_hop_cnt == (MAX_HOPS - 12'd1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hop_cnt <= 12'h000;
        end else if (r_state == IDLE && i_start) begin
            r_hop_cnt <= 12'h000;
        end else if (r_state == RD_DATA && i_mem_ack) begin
            r_hop_cnt <= r_hop_cnt + 12'd1;
        end
    end
`else
    assign w_hop_last = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_key         <= 16'h0000;
            r_cur_addr    <= 12'h000;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= 12'h000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_result_addr <= 12'h000;
            r_hop_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_key         <= i_key;
                        r_cur_addr    <= i_head_addr;
                        r_found       <= 1'b0;
                        r_result_addr <= 12'h000;
                        r_hop_err     <= 1'b0;
                        r_busy        <= 1'b1;
                        if (i_head_addr == 12'h000) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= RD_DATA;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= i_head_addr;
                        end
                    end
                end
                RD_DATA: begin
                    if (i_mem_ack) begin
                        if (w_match) begin
                            r_found       <= 1'b1;
                            r_result_addr <= r_cur_addr;
                            r_state       <= FIN;
                            r_done        <= 1'b1;
                            r_mem_rd      <= 1'b0;
                        end else if (w_hop_last) begin
                            r_hop_err <= 1'b1;
                            r_state   <= FIN;
                            r_done    <= 1'b1;
                            r_mem_rd  <= 1'b0;
                        end else begin
                            r_state    <= RD_NEXT;
                            r_mem_addr <= w_next_addr;
                        end
                    end
                end
                RD_NEXT: begin
                    if (i_mem_ack) begin
                        if (w_next_ptr == 12'h000) begin
                            r_state  <= FIN;
                            r_done   <= 1'b1;
                            r_mem_rd <= 1'b0;
                        end else begin
                            r_cur_addr <= w_next_ptr;
                            r_mem_addr <= w_next_ptr;
                            r_state    <= RD_DATA;
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_rd      = r_mem_rd;
    assign o_mem_addr    = r_mem_addr;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_found       = r_found;
    assign o_result_addr = r_result_addr;
    assign o_hop_err     = r_hop_err;

endmodule

// File: tb/tb_lnk_walker.sv
module tb_lnk_walker;

    typedef struct {
        logic        found;
        logic [11:0] addr;
        logic        herr;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [11:0] i_head_addr = 12'h000;
    logic [15:0] i_key = 16'h0000;
    logic        o_mem_rd;
    logic [11:0] o_mem_addr;
    logic        i_mem_ack = 1'b0;
    logic [15:0] i_mem_rdata = 16'h0000;
    logic        o_busy;
    logic        o_done;
    logic        o_found;
    logic [11:0] o_result_addr;
    logic        o_hop_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int dones = 0;
    int rd_cycles = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic [11:0] req_addr = 12'h000;

    logic [15:0] mem [0:4095];
    exp_t        exp_q [$];
    logic [11:0] rd_q [$];

    lnk_walker #(.MAX_HOPS(12'd4)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_head_addr   (i_head_addr),
        .i_key         (i_key),
        .o_mem_rd      (o_mem_rd),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_found       (o_found),
        .o_result_addr (o_result_addr),
        .o_hop_err     (o_hop_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // memory responder: ack after ack_delay wait cycles, check each read address
    initial forever begin
        @(posedge clk);
        #1;
        if (o_mem_rd) begin
            rd_cycles++;
            if (wait_cnt == 0) req_addr = o_mem_addr;
            else chk("addr_stable", {20'h0, o_mem_addr}, {20'h0, req_addr});
            if (wait_cnt == ack_delay) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem[o_mem_addr];
                wait_cnt    = 0;
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", o_mem_addr);
                end else begin
                    chk("read_addr", {20'h0, o_mem_addr}, {20'h0, rd_q.pop_front()});
                end
            end else begin
                i_mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            i_mem_ack = 1'b0;
            wait_cnt  = 0;
        end
    end

    // result monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (o_done) begin
            dones++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                e = exp_q.pop_front();
                chk("found", {31'h0, o_found}, {31'h0, e.found});
                chk("result_addr", {20'h0, o_result_addr}, {20'h0, e.addr});
                chk("hop_err", {31'h0, o_hop_err}, {31'h0, e.herr});
                chk("latency", cyc - start_cyc + 1, e.lat);
                chk("busy_at_done", {31'h0, o_busy}, 32'h1);
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_mem_rd"}, {31'h0, o_mem_rd}, 32'h0);
        chk({tag, "_mem_addr"}, {20'h0, o_mem_addr}, 32'h0);
        chk({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, o_done}, 32'h0);
        chk({tag, "_found"}, {31'h0, o_found}, 32'h0);
        chk({tag, "_result"}, {20'h0, o_result_addr}, 32'h0);
        chk({tag, "_hop_err"}, {31'h0, o_hop_err}, 32'h0);
    endtask

    task automatic run(input logic [11:0] head, input logic [15:0] key,
                       input logic fnd, input logic [11:0] raddr, input logic herr,
                       input int lat, input bit inj);
        exp_t e;
        int d0;
        int t;
        e.found = fnd;
        e.addr  = raddr;
        e.herr  = herr;
        e.lat   = lat;
        @(negedge clk);
        exp_q.push_back(e);
        i_head_addr = head;
        i_key       = key;
        i_start     = 1'b1;
        start_cyc   = cyc + 1;
        d0          = dones;
        @(negedge clk);
        i_start = 1'b0;
        if (inj) begin
            @(negedge clk);
            i_head_addr = 12'hFFF;
            i_key       = 16'h1234;
            i_start     = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
        end
        t = 0;
        while (dones == d0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", {31'h0, (dones != d0)}, 32'h1);
        repeat (3) @(negedge clk);
        chk("reads_consumed", rd_q.size(), 0);
        chk("idle_busy", {31'h0, o_busy}, 32'h0);
    endtask

    initial begin
        int rc;
        int t;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h010] = 16'h1234;
        mem[12'h011] = 16'hA020;
        mem[12'h020] = 16'hBEEF;
        mem[12'h021] = 16'h5000;
        mem[12'hFFF] = 16'h7777;
        mem[12'h000] = 16'hF000;
        mem[12'h030] = 16'h0000;
        mem[12'h031] = 16'h0030;

        // reset, with a start request held alongside it
        i_start = 1'b1;
        i_head_addr = 12'h010;
        repeat (3) @(negedge clk);
        i_start = 1'b0;
        i_reset = 1'b0;
        check_idle_zero("reset");
        @(negedge clk);
        chk("reset_no_read", rd_cycles, 0);

        // two-node list, match on second node
        rd_q.push_back(12'h010); rd_q.push_back(12'h011); rd_q.push_back(12'h020);
        run(12'h010, 16'hBEEF, 1'b1, 12'h020, 1'b0, 4, 1'b0);
        repeat (4) @(negedge clk);
        chk("found_held", {31'h0, o_found}, 32'h1);
        chk("result_held", {20'h0, o_result_addr}, 32'h020);

        // same list, miss
        rd_q.push_back(12'h010); rd_q.push_back(12'h011);
        rd_q.push_back(12'h020); rd_q.push_back(12'h021);
        run(12'h010, 16'h5555, 1'b0, 12'h000, 1'b0, 5, 1'b0);

        // match on head
        rd_q.push_back(12'h010);
        run(12'h010, 16'h1234, 1'b1, 12'h010, 1'b0, 2, 1'b0);

        // null head: no memory traffic at all
        rc = rd_cycles;
        run(12'h000, 16'h1234, 1'b0, 12'h000, 1'b0, 1, 1'b0);
        chk("null_head_no_read", rd_cycles - rc, 0);

        // node at FFF, pointer wraps to 000, slow memory
        ack_delay = 3;
        rd_q.push_back(12'hFFF); rd_q.push_back(12'h000);
        run(12'hFFF, 16'h1111, 1'b0, 12'h000, 1'b0, 9, 1'b0);

        // start while busy must be dropped
        rd_q.push_back(12'h010); rd_q.push_back(12'h011); rd_q.push_back(12'h020);
        run(12'h010, 16'hBEEF, 1'b1, 12'h020, 1'b0, 13, 1'b1);

        // reset during RD_NEXT after a dropped second start: no done, all zero
        rd_q.push_back(12'h010);
        @(negedge clk);
        i_head_addr = 12'h010;
        i_key       = 16'hBEEF;
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        i_head_addr = 12'hFFF;
        i_key       = 16'h1234;
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        t = 0;
        while (!(o_mem_rd && o_mem_addr == 12'h011) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reached_rd_next", {31'h0, (o_mem_rd && o_mem_addr == 12'h011)}, 32'h1);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check_idle_zero("midreset");
        repeat (20) @(negedge clk);
        chk("midreset_idle_busy", {31'h0, o_busy}, 32'h0);
        chk("midreset_reads", rd_q.size(), 0);
        rd_q.delete();

        // walker still usable after the abandoned search
        ack_delay = 0;
        rd_q.push_back(12'h010); rd_q.push_back(12'h011); rd_q.push_back(12'h020);
        run(12'h010, 16'hBEEF, 1'b1, 12'h020, 1'b0, 4, 1'b0);

`ifdef LNK_WALKER_HOP_LIMIT_EN
        // self-loop aborted after four data reads
        for (int i = 0; i < 3; i++) begin
            rd_q.push_back(12'h030);
            rd_q.push_back(12'h031);
        end
        rd_q.push_back(12'h030);
        run(12'h030, 16'hFFFF, 1'b0, 12'h000, 1'b1, 8, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lnk_walker.md
LNK_WALKER -- requirements
Module: lnk_walker

Interface
REQ-001 Parameter MAX_HOPS, default 12'd4095, maximum nodes visited per search; only used when LNK_WALKER_HOP_LIMIT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a search; ignored while busy=1.
REQ-005 head_addr  input  12  address of the first list node, sampled on an accepted start.
REQ-006 key  input  16  value searched for, sampled on an accepted start.
REQ-007 mem_rd  output  1  memory read request.
REQ-008 mem_addr  output  12  read address; stable while mem_rd=1.
REQ-009 mem_ack  input  1  read complete; mem_rdata is valid in the same cycle.
REQ-010 mem_rdata  input  16  read data.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse at the end of a search.
REQ-013 found  output  1  last search matched; held until the next accepted start.
REQ-014 result_addr  output  12  address of the matching node, else 12'h000; held until the next accepted start.
REQ-015 hop_err  output  1  last search aborted on the hop limit; held until the next accepted start.

Function
REQ-016 Node layout: word at node address N = data (16 bits); word at N+1 (12-bit add, 12'hFFF+1 wraps to 12'h000) = next pointer in bits [11:0]; bits [15:12] ignored; pointer 12'h000 = null.
REQ-017 States: IDLE, RD_DATA, RD_NEXT, FIN; FIN lasts exactly one cycle and asserts done.
REQ-018 IDLE + start: latch key; cur_addr <= head_addr; clear found, result_addr and hop_err; next state RD_DATA, or FIN if head_addr = 12'h000 (not found, no memory read).
REQ-019 RD_DATA: mem_rd=1, mem_addr=cur_addr; state held until mem_ack=1.
REQ-020 On mem_ack in RD_DATA with mem_rdata == key: found<=1, result_addr<=cur_addr, next state FIN; the pointer read is skipped.
REQ-021 On mem_ack in RD_DATA with no match: next state RD_NEXT.
REQ-022 RD_NEXT: mem_rd=1, mem_addr=cur_addr+1; state held until mem_ack=1.
REQ-023 On mem_ack in RD_NEXT: if mem_rdata[11:0] = 12'h000, next state FIN (not found); otherwise cur_addr <= mem_rdata[11:0] and next state RD_DATA.
REQ-024 mem_rd=0 in IDLE and FIN; mem_ack while mem_rd=0 is ignored.
REQ-025 busy=1 in RD_DATA, RD_NEXT and FIN; busy=0 in IDLE.
REQ-026 Latency with zero-wait memory (ack in the first request cycle): a match on node k (k=1 for the head node) gives done 2k cycles after the start cycle; a null head gives done 1 cycle after start.
REQ-027 start during busy is dropped; it is neither queued nor able to corrupt the latched key.
REQ-028 A self-loop or cyclic list without the hop limit walks indefinitely; this is legal behaviour.

Reset
REQ-029 With reset=1 at a rising edge: state=IDLE; mem_rd, busy, done, found and hop_err = 0; result_addr, mem_addr and the internal registers = 12'h000.
REQ-030 Reset mid-search abandons the search; no done pulse; a mem_ack in the reset cycle is ignored.
REQ-031 Reset has priority over start in the same cycle.

Configuration
REQ-032 Macro LNK_WALKER_HOP_LIMIT_EN defined: a 12-bit hop counter clears on an accepted start and increments on each RD_DATA mem_ack.
REQ-033 With the macro defined, a non-matching RD_DATA ack while hop count = MAX_HOPS-1 sets hop_err=1 and goes to FIN with found=0.
REQ-034 Macro undefined: no hop counter; hop_err tied to 0; MAX_HOPS unused.

Verification
REQ-035 List 0x010(0x1234, next 0x020) -> 0x020(0xBEEF, next 0), key 0xBEEF, zero-wait memory -> done at start+4, found=1, result_addr=0x020.
REQ-036 Same list, key 0x5555 -> 4 reads (0x010, 0x011, 0x020, 0x021), done, found=0, result_addr=0x000.
REQ-037 head_addr=0x000 -> done at start+1, mem_rd never asserted, found=0.
REQ-038 Node at 0xFFF with next pointer stored at 0x000, 3-cycle ack delay -> mem_addr=0x000 on the pointer read; mem_addr and mem_rd stable through the wait.
REQ-039 Second start pulse mid-search plus reset asserted during RD_NEXT -> second start ignored; after reset, all outputs 0, state IDLE, no done pulse.
REQ-040 With LNK_WALKER_HOP_LIMIT_EN and MAX_HOPS=4, self-loop node 0x030 (next 0x030), unmatched key -> 4 data reads, then hop_err=1, found=0, done.
